// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - client-side memory requester: ID stamping, request push, response matching
// Optional feature macro: MEM_REQUESTER_TIMEOUT_EN (per-entry age counters with forced release).
module mem_requester #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 31,
  parameter int TID_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int REQ_WIDTH       = 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int DP_DATA_WIDTH   = TID_WIDTH + REQ_WIDTH,
  parameter int VPI_DATA_WIDTH  = TID_WIDTH + DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rw,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_data,
  output logic                      req_wr_en,
  output logic [DP_DATA_WIDTH-1:0]  req_data,
  input  logic                      req_full,
  output logic                      rsp_rd_en,
  input  logic [VPI_DATA_WIDTH-1:0] rsp_fifo_data,
  input  logic                      rsp_empty,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [TID_WIDTH-1:0]      rsp_id,
  output logic                      rsp_rw,
  output logic [ADDR_WIDTH-1:0]     rsp_addr,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic [3:0]                outstanding,
  output logic [7:0]                stray_cnt,
  output logic [7:0]                timeout_cnt
);

  localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0]     MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TID_WIDTH-1:0] FIRST_ID = TID_WIDTH'(1);

  // Outstanding-transaction table
  logic [MAX_OUTSTANDING-1:0] r_tab_valid;
  logic [MAX_OUTSTANDING-1:0] r_tab_rw;
  logic [TID_WIDTH-1:0]       r_tab_id   [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0]      r_tab_addr [MAX_OUTSTANDING];

  logic [TID_WIDTH-1:0]  r_next_id;
  logic                  r_rsp_valid;
  logic [TID_WIDTH-1:0]  r_rsp_id;
  logic                  r_rsp_rw;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [7:0]            r_stray_cnt;

  logic [CNT_W-1:0]           w_count;
  logic                       w_free_found;
  logic [IDX_W-1:0]           w_free_idx;
  logic                       w_issue;
  logic                       w_pop;
  logic [TID_WIDTH-1:0]       w_fifo_id;
  logic [DATA_WIDTH-1:0]      w_fifo_data;
  logic                       w_hit;
  logic [IDX_W-1:0]           w_hit_idx;
  logic                       w_retire;
  logic                       w_stray;
  logic [MAX_OUTSTANDING-1:0] w_retire_vec;
  logic [MAX_OUTSTANDING-1:0] w_expire;
  logic [MAX_OUTSTANDING-1:0] w_release;

  assign w_fifo_id   = rsp_fifo_data[VPI_DATA_WIDTH-1 -: TID_WIDTH];
  assign w_fifo_data = rsp_fifo_data[DATA_WIDTH-1:0];

  // Occupancy count and lowest-index free entry, both from pre-edge table state
  always_comb begin
    w_count      = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      w_count = w_count + CNT_W'(r_tab_valid[i]);
      if (!r_tab_valid[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  assign cmd_ready = !reset && !req_full && (w_count < MAX_CNT);
  assign w_issue   = cmd_valid && cmd_ready && w_free_found;
  assign req_wr_en = w_issue;
  assign req_data  = {r_next_id, cmd_rw, cmd_addr, cmd_data};

  // Pop whenever the output slot is empty or is being handed off this cycle
  assign w_pop     = !reset && !rsp_empty && (!r_rsp_valid || rsp_ready);
  assign rsp_rd_en = w_pop;

  // Parallel ID lookup; ID 0 is filler and never matches
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (r_tab_valid[i] && (r_tab_id[i] == w_fifo_id) && (w_fifo_id != '0) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_retire = w_pop && w_hit;
  assign w_stray  = w_pop && !w_hit && (w_fifo_id != '0);

  // One-hot of the entry retired this cycle
  always_comb begin
    w_retire_vec = '0;
    if (w_retire) begin
      w_retire_vec[w_hit_idx] = 1'b1;
    end
  end

  assign w_release = w_retire_vec | w_expire;

`ifdef MEM_REQUESTER_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT_CYCLES - 1);

  logic [AGE_W-1:0] r_tab_age [MAX_OUTSTANDING];
  logic [7:0]       r_timeout_cnt;
  logic [CNT_W-1:0] w_expire_cnt;
  logic [8:0]       w_timeout_sum;

  // Entries at their last age expire unless a matching response retires them now
  always_comb begin
    w_expire     = '0;
    w_expire_cnt = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (r_tab_valid[i] && (r_tab_age[i] == AGE_LAST) && !w_retire_vec[i]) begin
        w_expire[i]  = 1'b1;
        w_expire_cnt = w_expire_cnt + CNT_W'(1);
      end
    end
  end

  // Age counters: cleared on allocation, advance while the entry is live
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tab_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (w_issue && (w_free_idx == IDX_W'(i))) begin
          r_tab_age[i] <= '0;
        end else if (r_tab_valid[i]) begin
          r_tab_age[i] <= r_tab_age[i] + AGE_W'(1);
        end
      end
    end
  end

  assign w_timeout_sum = {1'b0, r_timeout_cnt} + 9'(w_expire_cnt);

  // Saturating count of forced releases
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout_cnt <= '0;
    end else if (w_timeout_sum > 9'd255) begin
      r_timeout_cnt <= 8'hFF;
    end else begin
      r_timeout_cnt <= w_timeout_sum[7:0];
    end
  end

  assign timeout_cnt = r_timeout_cnt;
`else
  // Lifetime parameter only matters in the timeout build
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
  assign w_expire         = '0;
  assign timeout_cnt      = '0;
`endif

  // Table update: releases first, then allocation of the pre-edge free entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tab_valid <= '0;
      r_tab_rw    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tab_id[i]   <= '0;
        r_tab_addr[i] <= '0;
      end
    end else begin
      r_tab_valid <= r_tab_valid & ~w_release;
      if (w_issue) begin
        r_tab_valid[w_free_idx] <= 1'b1;
        r_tab_rw[w_free_idx]    <= cmd_rw;
        r_tab_id[w_free_idx]    <= r_next_id;
        r_tab_addr[w_free_idx]  <= cmd_addr;
      end
    end
  end

  // ID generator: 1..2^TID_WIDTH-1, skipping 0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_next_id <= FIRST_ID;
    end else if (w_issue) begin
      r_next_id <= (r_next_id == '1) ? FIRST_ID : r_next_id + FIRST_ID;
    end
  end

  // Response slot: load on match, clear on handshake without a replacement
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rw    <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
    end else if (w_retire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_tab_id[w_hit_idx];
      r_rsp_rw    <= r_tab_rw[w_hit_idx];
      r_rsp_addr  <= r_tab_addr[w_hit_idx];
      r_rsp_data  <= w_fifo_data;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Saturating count of non-zero responses with no matching entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stray_cnt <= '0;
    end else if (w_stray && (r_stray_cnt != 8'hFF)) begin
      r_stray_cnt <= r_stray_cnt + 8'd1;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_rw    = r_rsp_rw;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_data  = r_rsp_data;
  assign stray_cnt = r_stray_cnt;
  // A full 16-entry table cannot be shown in 4 bits; report 15 in that case
  assign outstanding = (w_count > CNT_W'(15)) ? 4'hF : w_count[3:0];

endmodule

// File: tb/tb_mem_requester.sv
// tb/tb_mem_requester.sv - self-checking bench for mem_requester
module tb_mem_requester;

  typedef struct packed {
    logic        rw;
    logic [30:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  typedef struct packed {
    logic [15:0] id;
    logic        rw;
    logic [30:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [30:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        req_wr_en;
  logic [79:0] req_data;
  logic        req_full;
  logic        rsp_rd_en;
  logic [47:0] rsp_fifo_data;
  logic        rsp_empty;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_id;
  logic        rsp_rw;
  logic [30:0] rsp_addr;
  logic [31:0] rsp_data;
  logic [3:0]  outstanding;
  logic [7:0]  stray_cnt;
  logic [7:0]  timeout_cnt;

  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [7:0]  s_cmd_addr;
  logic        s_req_wr_en;
  logic [20:0] s_req_data;
  logic        s_rsp_rd_en;
  logic [11:0] s_rsp_fifo_data;
  logic        s_rsp_empty;
  logic        s_rsp_valid;
  logic [3:0]  s_rsp_id;
  logic        s_rsp_rw;
  logic [7:0]  s_rsp_addr;
  logic [7:0]  s_rsp_data;
  logic [3:0]  s_outstanding;
  logic [7:0]  s_stray_cnt;
  logic [7:0]  s_timeout_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [47:0] rsp_q [$];
  exp_t        exp_q [$];
  logic [31:0] m_cmd [int];
  logic [15:0] exp_next_id;
  vec_t        vecs [4];

  mem_requester #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .req_wr_en(req_wr_en), .req_data(req_data), .req_full(req_full),
    .rsp_rd_en(rsp_rd_en), .rsp_fifo_data(rsp_fifo_data), .rsp_empty(rsp_empty),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rw(rsp_rw),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .outstanding(outstanding), .stray_cnt(stray_cnt), .timeout_cnt(timeout_cnt)
  );

  mem_requester #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TID_WIDTH(4), .MAX_OUTSTANDING(2)) dut_small (
    .clk(clk), .reset(reset),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_rw(1'b0),
    .cmd_addr(s_cmd_addr), .cmd_data(8'h00),
    .req_wr_en(s_req_wr_en), .req_data(s_req_data), .req_full(1'b0),
    .rsp_rd_en(s_rsp_rd_en), .rsp_fifo_data(s_rsp_fifo_data), .rsp_empty(s_rsp_empty),
    .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_id(s_rsp_id), .rsp_rw(s_rsp_rw),
    .rsp_addr(s_rsp_addr), .rsp_data(s_rsp_data),
    .outstanding(s_outstanding), .stray_cnt(s_stray_cnt), .timeout_cnt(s_timeout_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic update_fifo();
    rsp_empty     = (rsp_q.size() == 0);
    rsp_fifo_data = rsp_empty ? 48'h0 : rsp_q[0];
  endtask

  // One clock: sample pre-edge decisions, advance, then model FIFO and scoreboard
  task automatic tick();
    logic pre_pop;
    logic pre_hs;
    exp_t got;
    exp_t e;
    #1;
    pre_pop = rsp_rd_en;
    pre_hs  = rsp_valid && rsp_ready;
    got     = {rsp_id, rsp_rw, rsp_addr, rsp_data};
    @(posedge clk);
    #1;
    if (pre_pop && rsp_q.size() > 0) void'(rsp_q.pop_front());
    update_fifo();
    if (pre_hs) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got id %0h expected no response", got.id);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rsp", got, e);
      end
    end
  endtask

  task automatic issue(input logic rw, input logic [30:0] addr, input logic [31:0] data, input string tag);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_data  = data;
    #1;
    chk({tag, "_wr_en"}, req_wr_en, 1'b1);
    chk({tag, "_req_data"}, req_data, {exp_next_id, rw, addr, data});
    m_cmd[int'(exp_next_id)] = {rw, addr};
    exp_next_id = (exp_next_id == 16'hFFFF) ? 16'd1 : exp_next_id + 16'd1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic respond(input logic [15:0] id, input logic [31:0] data);
    logic [31:0] c;
    rsp_q.push_back({id, data});
    if (m_cmd.exists(int'(id))) begin
      c = m_cmd[int'(id)];
      exp_q.push_back({id, c[31], c[30:0], data});
      m_cmd.delete(int'(id));
    end
    update_fifo();
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200 && (rsp_q.size() > 0 || rsp_valid); k++) tick();
    chk({tag, "_drained"}, (rsp_q.size() == 0) && !rsp_valid, 1'b1);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic do_reset(input string tag);
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    rsp_ready   = 1'b0;
    s_cmd_valid = 1'b0;
    #1;
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    chk({tag, "_rd_en"}, rsp_rd_en, 1'b0);
    tick();
    tick();
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_fields"}, {rsp_id, rsp_rw, rsp_addr, rsp_data}, 80'h0);
    chk({tag, "_counts"}, {outstanding, stray_cnt, timeout_cnt}, 20'h0);
    reset       = 1'b0;
    rsp_ready   = 1'b1;
    rsp_q.delete();
    exp_q.delete();
    m_cmd.delete();
    exp_next_id = 16'd1;
    update_fifo();
  endtask

  initial begin
    logic [15:0] id;
    logic [3:0]  eid;
    reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
    req_full = 1'b0; rsp_ready = 1'b0; exp_next_id = 16'd1;
    s_cmd_valid = 1'b0; s_cmd_addr = '0; s_rsp_fifo_data = '0; s_rsp_empty = 1'b1;
    update_fifo();

    vecs[0] = '{rw: 1'b0, addr: 31'h0,        wdata: 32'hFFFF_FFFF, rdata: 32'h0};
    vecs[1] = '{rw: 1'b1, addr: 31'h7FFF_FFFF, wdata: 32'h1234_5678, rdata: 32'hDEAD_BEEF};
    vecs[2] = '{rw: 1'b0, addr: 31'h2AAA_AAAA, wdata: 32'h5555_5555, rdata: 32'hAAAA_AAAA};
    vecs[3] = '{rw: 1'b1, addr: 31'h1,        wdata: 32'h0,         rdata: 32'hFFFF_FFFF};

    do_reset("rst0");

    // First transaction: read 0x10, response next cycle after pop
    issue(1'b1, 31'h10, 32'h0BAD_F00D, "t1");
    chk("t1_outstanding", outstanding, 4'd1);
    respond(16'd1, 32'hCAFE);
    #1;
    chk("t1_rd_en", rsp_rd_en, 1'b1);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_fields", {rsp_id, rsp_addr, rsp_data}, {16'd1, 31'h10, 32'hCAFE});
    chk("t1_outstanding_after", outstanding, 4'd0);
    drain("t1");

    // Table-driven single transactions
    for (int v = 0; v < 4; v++) begin
      id = exp_next_id;
      issue(vecs[v].rw, vecs[v].addr, vecs[v].wdata, "vec");
      respond(id, vecs[v].rdata);
      tick();
      chk("vec_rsp_valid", rsp_valid, 1'b1);
      chk("vec_outstanding", outstanding, 4'd0);
    end
    drain("vec");

    // Fill the table, back-pressure, retire ID 5, refill entry 4
    do_reset("rst1");
    for (int k = 0; k < 8; k++) issue(k[0], 31'(32'h100 + k), 32'(k), "fill");
    chk("fill_outstanding", outstanding, 4'd8);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 31'h999; cmd_data = 32'h99;
    #1;
    chk("fill_cmd_ready", cmd_ready, 1'b0);
    chk("fill_no_push", req_wr_en, 1'b0);
    tick();
    respond(16'd5, 32'h55);
    tick();
    chk("fill_ready_after_retire", cmd_ready, 1'b1);
    issue(1'b0, 31'h999, 32'h99, "refill");
    chk("refill_entry4_id", dut.r_tab_id[4], 16'd9);
    chk("refill_outstanding", outstanding, 4'd8);

    // Hold rsp_ready low with three responses queued
    rsp_ready = 1'b0;
    respond(16'd1, 32'hA1);
    respond(16'd2, 32'hA2);
    respond(16'd3, 32'hA3);
    tick();
    chk("hold_first", {rsp_valid, rsp_id, rsp_data}, {1'b1, 16'd1, 32'hA1});
    tick();
    tick();
    chk("hold_one_pop", rsp_q.size(), 2);
    chk("hold_stable", {rsp_valid, rsp_id, rsp_addr, rsp_data}, {1'b1, 16'd1, 31'h100, 32'hA1});
    rsp_ready = 1'b1;
    tick();
    chk("release_1", {rsp_valid, rsp_id}, {1'b1, 16'd2});
    tick();
    chk("release_2", {rsp_valid, rsp_id}, {1'b1, 16'd3});
    tick();
    chk("release_3", rsp_valid, 1'b0);
    respond(16'd4, 32'hB4);
    respond(16'd6, 32'hB6);
    respond(16'd7, 32'hB7);
    respond(16'd8, 32'hB8);
    respond(16'd9, 32'hB9);
    drain("fill");
    chk("fill_empty", outstanding, 4'd0);
    chk("fill_no_timeout", timeout_cnt, 8'd0);

    // Filler and stray responses
    do_reset("rst2");
    respond(16'd0, 32'h1);
    respond(16'h1234, 32'h2);
    drain("stray");
    chk("stray_cnt", stray_cnt, 8'd1);

    // Issue and retire in the same cycle
    issue(1'b0, 31'h20, 32'h20, "same_a");
    respond(16'd1, 32'hC1);
    issue(1'b1, 31'h24, 32'h24, "same_b");
    chk("same_outstanding", outstanding, 4'd1);
    chk("same_entry_map", {dut.r_tab_valid, dut.r_tab_id[1]}, {8'b0000_0010, 16'd2});
    respond(16'd2, 32'hC2);
    drain("same");

    // Mid-operation reset turns late responses into strays
    issue(1'b1, 31'h30, 32'h0, "mid_a");
    id = exp_next_id;
    issue(1'b1, 31'h34, 32'h0, "mid_b");
    do_reset("rst3");
    respond(id, 32'hD0);
    drain("mid");
    chk("mid_stray_cnt", stray_cnt, 8'd1);
    issue(1'b0, 31'h40, 32'h0, "mid_new_id");
    respond(16'd1, 32'hD1);
    drain("mid_new");

    // ID wrap on a 4-bit ID instance: 1..15 then 1
    for (int k = 0; k < 16; k++) begin
      eid = (k == 15) ? 4'd1 : 4'(k + 1);
      s_cmd_valid = 1'b1;
      s_cmd_addr  = 8'(k);
      #1;
      chk("wrap_push", {s_req_wr_en, s_req_data[20:17]}, {1'b1, eid});
      tick();
      s_cmd_valid     = 1'b0;
      s_rsp_fifo_data = {eid, 8'h00};
      s_rsp_empty     = 1'b0;
      tick();
      s_rsp_empty     = 1'b1;
      chk("wrap_retired", {s_rsp_valid, s_rsp_id, s_outstanding}, {1'b1, eid, 4'd0});
    end
    chk("wrap_no_stray", s_stray_cnt, 8'd0);

`ifdef MEM_REQUESTER_TIMEOUT_EN
    // Forced release 16 cycles after issue
    do_reset("rst4");
    id = exp_next_id;
    issue(1'b1, 31'h50, 32'h0, "tmo");
    m_cmd.delete(int'(id));
    repeat (15) tick();
    chk("tmo_still_live", outstanding, 4'd1);
    tick();
    chk("tmo_released", {outstanding, timeout_cnt}, {4'd0, 8'd1});
    respond(id, 32'hE0);
    drain("tmo");
    chk("tmo_late_stray", stray_cnt, 8'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
